// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between a CPU port (0) and a loader port (1).
// Define DMEM_ARB_FIXED_PRIORITY_EN to make port 0 win every tie instead of alternating.
module data_memory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 1024
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req0_i,
  input  logic                  wr0_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  output logic                  ack0_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic                  err0_o,
  input  logic                  req1_i,
  input  logic                  wr1_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  ack1_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic                  err1_o,
  output logic [ADDR_WIDTH-1:0] memAddress_o,
  output logic [DATA_WIDTH-1:0] memWriteData_o,
  output logic                  memWriteEnable_o,
  input  logic [DATA_WIDTH-1:0] memReadData_i,
  output logic                  busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);

  logic [1:0]            state_q, state_d;
  logic                  winner_q, winner_d;
  logic                  lastServed_q, lastServed_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] memAddress_q, memAddress_d;
  logic [DATA_WIDTH-1:0] memWriteData_q, memWriteData_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  err0_q, err0_d;
  logic                  err1_q, err1_d;

  logic                  grant;
  logic                  inRange;
  logic [ADDR_WIDTH-1:0] addrSel;
  logic [DATA_WIDTH-1:0] captureData;

  assign inRange     = (memAddress_q < MEM_LIMIT);
  assign captureData = inRange ? memReadData_i : '0;

  // grant is only meaningful when at least one request is pending
  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
    grant = ~req0_i;
`else
    grant = (req0_i & req1_i) ? ~lastServed_q : ~req0_i;
`endif
    addrSel = grant ? addr1_i : addr0_i;
  end

  always_comb begin
    state_d        = state_q;
    winner_d       = winner_q;
    lastServed_d   = lastServed_q;
    wr_d           = wr_q;
    memAddress_d   = memAddress_q;
    memWriteData_d = memWriteData_q;
    rdata0_d       = rdata0_q;
    rdata1_d       = rdata1_q;
    ack0_d         = 1'b0;
    ack1_d         = 1'b0;
    err0_d         = 1'b0;
    err1_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0_i | req1_i) begin
          winner_d       = grant;
          wr_d           = grant ? wr1_i : wr0_i;
          memAddress_d   = addrSel & WORD_MASK;
          memWriteData_d = grant ? wdata1_i : wdata0_i;
          state_d        = SERVE;
        end
      end
      SERVE: begin
        // out-of-range accesses also clear the read data, writes included
        if (!wr_q || !inRange) begin
          if (winner_q) rdata1_d = captureData;
          else          rdata0_d = captureData;
        end
        ack0_d  = ~winner_q;
        ack1_d  = winner_q;
        err0_d  = ~winner_q & ~inRange;
        err1_d  = winner_q & ~inRange;
        state_d = ACK;
      end
      ACK: begin
        lastServed_d = winner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      winner_q       <= 1'b0;
      lastServed_q   <= 1'b1;
      wr_q           <= 1'b0;
      memAddress_q   <= '0;
      memWriteData_q <= '0;
      rdata0_q       <= '0;
      rdata1_q       <= '0;
      ack0_q         <= 1'b0;
      ack1_q         <= 1'b0;
      err0_q         <= 1'b0;
      err1_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      winner_q       <= winner_d;
      lastServed_q   <= lastServed_d;
      wr_q           <= wr_d;
      memAddress_q   <= memAddress_d;
      memWriteData_q <= memWriteData_d;
      rdata0_q       <= rdata0_d;
      rdata1_q       <= rdata1_d;
      ack0_q         <= ack0_d;
      ack1_q         <= ack1_d;
      err0_q         <= err0_d;
      err1_q         <= err1_d;
    end
  end

  // reset gates the strobe directly so a write racing a reset edge never lands
  assign memWriteEnable_o = (state_q == SERVE) & wr_q & inRange & ~reset_i;
  assign memAddress_o     = memAddress_q;
  assign memWriteData_o   = memWriteData_q;
  assign ack0_o           = ack0_q;
  assign ack1_o           = ack1_q;
  assign err0_o           = err0_q;
  assign err1_o           = err1_q;
  assign rdata0_o         = rdata0_q;
  assign rdata1_o         = rdata1_q;
  assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural 1KB memory behind it.
// Honours DMEM_ARB_FIXED_PRIORITY_EN for the tie-break expectations.
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, wr0, wr1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1, busy, memWriteEnable;
  logic [31:0] rdata0, rdata1, memAddress, memWriteData, memReadData;
  logic [31:0] mem [0:255];
  logic [31:0] expOrder [4];

  int checkCount = 0;
  int errorCount = 0;
  int weCount = 0;
  int ackCount = 0;
  int dualAckCount = 0;
  int weOutsideCount = 0;

  always #5 clk = ~clk;

  data_memory_arbiter dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .req0_i           (req0),
    .wr0_i            (wr0),
    .addr0_i          (addr0),
    .wdata0_i         (wdata0),
    .ack0_o           (ack0),
    .rdata0_o         (rdata0),
    .err0_o           (err0),
    .req1_i           (req1),
    .wr1_i            (wr1),
    .addr1_i          (addr1),
    .wdata1_i         (wdata1),
    .ack1_o           (ack1),
    .rdata1_o         (rdata1),
    .err1_o           (err1),
    .memAddress_o     (memAddress),
    .memWriteData_o   (memWriteData),
    .memWriteEnable_o (memWriteEnable),
    .memReadData_i    (memReadData),
    .busy_o           (busy)
  );

  always @(posedge clk) begin
    if (memWriteEnable) mem[memAddress[9:2]] <= memWriteData;
  end

  assign memReadData = (memAddress < 32'd1024) ? mem[memAddress[9:2]] : 32'd0;

  // protocol monitor samples after the main process has read the counters
  always begin
    @(negedge clk);
    #2;
    if (memWriteEnable) weCount++;
    if (ack0 || ack1) ackCount++;
    if (ack0 && ack1) dualAckCount++;
    if (memWriteEnable && !busy) weOutsideCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit port, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input string tag);
    int latency;
    @(negedge clk);
    if (port) begin req1 = 1'b1; wr1 = wr; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; wr0 = wr; addr0 = addr; wdata0 = wdata; end
    latency = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if ((!port && ack0) || (port && ack1)) begin
        latency = i;
        break;
      end
    end
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
    checkOutput({tag, "_latency"}, 32'(latency), 32'd2);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int weBefore;
    int ackBefore;
    int nAck;
    int firstPort;
    logic [31:0] gotPort;
    logic done0, done1;

`ifdef DMEM_ARB_FIXED_PRIORITY_EN
    expOrder[0] = 32'd0; expOrder[1] = 32'd0; expOrder[2] = 32'd0; expOrder[3] = 32'd0;
`else
    expOrder[0] = 32'd0; expOrder[1] = 32'd1; expOrder[2] = 32'd0; expOrder[3] = 32'd1;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_ack0", {31'd0, ack0}, 32'd0);
    checkOutput("reset_ack1", {31'd0, ack1}, 32'd0);
    checkOutput("reset_we", {31'd0, memWriteEnable}, 32'd0);
    checkOutput("reset_rdata0", rdata0, 32'd0);
    checkOutput("reset_rdata1", rdata1, 32'd0);
    reset = 1'b0;

    // write then read back through the unaligned alias
    weBefore = weCount;
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10");
    checkOutput("wr10_weCycles", 32'(weCount - weBefore), 32'd1);
    checkOutput("wr10_err0", {31'd0, err0}, 32'd0);
    checkOutput("wr10_mem", mem[4], 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 32'h13, 32'd0, "rd13");
    checkOutput("rd13_rdata0", rdata0, 32'hDEADBEEF);
    checkOutput("rd13_err0", {31'd0, err0}, 32'd0);

    // simultaneous continuous reads from a fresh reset
    mem[16] = 32'hA5A50040;
    mem[17] = 32'hA5A50044;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h40;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h44;
    nAck = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        gotPort = {31'd0, ack1};
        checkOutput($sformatf("rr_order%0d", nAck), gotPort, expOrder[nAck]);
        checkOutput($sformatf("rr_rdata%0d", nAck), ack1 ? rdata1 : rdata0,
                    (expOrder[nAck] == 32'd1) ? 32'hA5A50044 : 32'hA5A50040);
        nAck++;
        if (nAck == 4) break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checkOutput("rr_ackTotal", 32'(nAck), 32'd4);
    repeat (2) @(negedge clk);

    // out-of-range write, then last in-range word
    mem[255] = 32'h0BADF00D;
    weBefore = weCount;
    applyStimulus(1'b1, 1'b1, 32'h400, 32'hFFFFFFFF, "wr400");
    checkOutput("wr400_weCycles", 32'(weCount - weBefore), 32'd0);
    checkOutput("wr400_err1", {31'd0, err1}, 32'd1);
    checkOutput("wr400_rdata1", rdata1, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h3FC, 32'd0, "rd3fc");
    checkOutput("rd3fc_err1", {31'd0, err1}, 32'd0);
    checkOutput("rd3fc_rdata1", rdata1, 32'h0BADF00D);

    // reset lands while a write is in SERVE
    @(negedge clk);
    ackBefore = ackCount;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hCAFEF00D;
    @(negedge clk);
    checkOutput("rstServe_busy", {31'd0, busy}, 32'd1);
    checkOutput("rstServe_we", {31'd0, memWriteEnable}, 32'd1);
    reset = 1'b1;
    req0 = 1'b0;
    #1;
    checkOutput("rstServe_weSuppressed", {31'd0, memWriteEnable}, 32'd0);
    @(negedge clk);
    checkOutput("rstServe_idle", {31'd0, busy}, 32'd0);
    checkOutput("rstServe_ack0", {31'd0, ack0}, 32'd0);
    checkOutput("rstServe_mem20", mem[8], 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstServe_noAck", 32'(ackCount - ackBefore), 32'd0);

    // port 1 reads the word port 0 is writing in the same tie
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h12345678;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h10; wdata1 = 32'd0;
    done0 = 1'b0; done1 = 1'b0; firstPort = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack0) begin
        if (firstPort < 0) firstPort = 0;
        req0 = 1'b0; done0 = 1'b1;
        checkOutput("wrRead_err0", {31'd0, err0}, 32'd0);
      end
      if (ack1) begin
        if (firstPort < 0) firstPort = 1;
        req1 = 1'b0; done1 = 1'b1;
        checkOutput("wrRead_rdata1", rdata1, 32'h12345678);
      end
      if (done0 && done1) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    checkOutput("wrRead_first", 32'(firstPort), 32'd0);
    checkOutput("wrRead_done", {30'd0, done0, done1}, 32'd3);
    repeat (2) @(negedge clk);

    checkOutput("dualAck", 32'(dualAckCount), 32'd0);
    checkOutput("weOutsideServe", 32'(weOutsideCount), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
